ubus_arbiter: RTL and testbench

Central bus arbiter and phase sequencer for the UBus fabric. It drives `ubus_start`, grants one of `NUM_MASTERS` requesters in round-robin order, and tracks each transfer through its address and data phases. It also counts data beats from `ubus_size`, and monitors `ubus_wait`, `ubus_bip` and `ubus_error` to decide when the bus returns to arbitration. It sits beside the masters and slaves on the shared `ubus_if` signal set and is the only driver of start and grants.

---
 rtl/ubus_pkg.sv | 22 ++
 rtl/ubus_if.sv | 37 +++
 rtl/ubus_rr_picker.sv | 25 ++
 rtl/ubus_arbiter.sv | 116 +++++++++++
 tb/tb_ubus_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ubus_pkg.sv
// Shared UBus types and helpers: phase enum, size decode, index widths.
package ubus_pkg;

  localparam int unsigned UBUS_SIZE_W = 2;
  localparam int unsigned BEAT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } ubus_state_e;

  function automatic logic [BEAT_CNT_W-1:0] size_to_beats(input logic [UBUS_SIZE_W-1:0] size);
    return BEAT_CNT_W'(1) << size;
  endfunction

  // Width of an index/counter for n values, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ubus_if.sv
// UBus shared signal set seen by the arbiter, masters and slaves.
interface ubus_if
  import ubus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
);
  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] ubus_req;
  logic [NUM_MASTERS-1:0] ubus_gnt;
  logic                   ubus_start;
  logic                   ubus_read;
  logic                   ubus_write;
  logic [UBUS_SIZE_W-1:0] ubus_size;
  logic                   ubus_bip;
  logic                   ubus_wait;
  logic                   ubus_error;
  logic [IDX_W-1:0]       cur_master;
  logic                   protocol_err;
  logic                   timeout_err;

  modport arb (
    input  ubus_req, ubus_read, ubus_write, ubus_size, ubus_bip, ubus_wait, ubus_error,
    output ubus_gnt, ubus_start, cur_master, protocol_err, timeout_err
  );

  modport master (
    input  ubus_gnt, ubus_start, ubus_wait, ubus_error,
    output ubus_req, ubus_read, ubus_write, ubus_size, ubus_bip
  );

  modport slave (
    input  ubus_start, ubus_read, ubus_write, ubus_size, ubus_bip,
    output ubus_wait, ubus_error
  );

endinterface

// File: rtl/ubus_rr_picker.sv
// Combinational round-robin search starting just after the last winner.
module ubus_rr_picker
  import ubus_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic                   found_o_c,
  output logic [IDX_W-1:0]       winner_o_c
);

  always_comb begin
    found_o_c  = 1'b0;
    winner_o_c = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!found_o_c && req_i[(32'(last_i) + 32'd1 + i) % NUM_MASTERS]) begin
        found_o_c  = 1'b1;
        winner_o_c = IDX_W'((32'(last_i) + 32'd1 + i) % NUM_MASTERS);
      end
    end
  end

endmodule

// File: rtl/ubus_arbiter.sv
// UBus central arbiter: round-robin grant, ARB/ADDR/DATA sequencing,
// beat counting, wait timeout and protocol checking.
module ubus_arbiter
  import ubus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 2,
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input logic ubus_clock,
  input logic ubus_reset,
  ubus_if.arb bus
);

  localparam int unsigned IDX_W  = idx_width(NUM_MASTERS);
  localparam int unsigned WCNT_W = idx_width(WAIT_TIMEOUT);

  ubus_state_e            state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic                   start_q;
  logic [IDX_W-1:0]       cur_q;
  logic [IDX_W-1:0]       last_q;
  logic                   perr_q, perr_d;
  logic                   terr_q, terr_d;
  logic [BEAT_CNT_W-1:0]  beats_left_q;
  logic [WCNT_W-1:0]      wcnt_q;

  logic                   found_c;
  logic [IDX_W-1:0]       winner_c;
  logic                   beat_done_c;
  logic                   wait_step_c;

  ubus_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req_i      (bus.ubus_req),
    .last_i     (last_q),
    .found_o_c  (found_c),
    .winner_o_c (winner_c)
  );

  // Next phase and error detection from the current phase and bus status.
  always_comb begin
    state_d     = state_q;
    perr_d      = 1'b0;
    terr_d      = 1'b0;
    beat_done_c = 1'b0;
    wait_step_c = 1'b0;
    case (state_q)
      // An ARB without start is the post-reset hold; it re-enters a real ARB.
      ARB: state_d = start_q ? ADDR : ARB;
      ADDR: begin
        perr_d  = bus.ubus_read & bus.ubus_write;
        state_d = ((|gnt_q) && (bus.ubus_read ^ bus.ubus_write)) ? DATA : ARB;
      end
      DATA: begin
        if (bus.ubus_error) begin
          state_d = ARB;
        end else if (!bus.ubus_wait) begin
          beat_done_c = 1'b1;
          if (beats_left_q == BEAT_CNT_W'(1)) begin
            perr_d  = bus.ubus_bip;
            state_d = ARB;
          end else begin
            perr_d = !bus.ubus_bip;
          end
        end else if (wcnt_q == WCNT_W'(WAIT_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = ARB;
        end else begin
          wait_step_c = 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge ubus_clock) begin
    if (!ubus_reset) begin
      state_q      <= ARB;
      gnt_q        <= '0;
      start_q      <= 1'b0;
      cur_q        <= '0;
      last_q       <= IDX_W'(NUM_MASTERS - 1);
      perr_q       <= 1'b0;
      terr_q       <= 1'b0;
      beats_left_q <= '0;
      wcnt_q       <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == ARB);
      perr_q  <= perr_d;
      terr_q  <= terr_d;
      // Grant is recomputed on every entry to ARB and held otherwise.
      if (state_d == ARB) begin
        gnt_q <= found_c ? (NUM_MASTERS'(1) << winner_c) : '0;
        cur_q <= found_c ? winner_c : '0;
        if (found_c) begin
          last_q <= winner_c;
        end
      end
      if (state_q == ADDR) begin
        beats_left_q <= size_to_beats(bus.ubus_size);
      end else if (beat_done_c) begin
        beats_left_q <= beats_left_q - BEAT_CNT_W'(1);
      end
      wcnt_q <= wait_step_c ? (wcnt_q + WCNT_W'(1)) : '0;
    end
  end

  assign bus.ubus_gnt     = gnt_q;
  assign bus.ubus_start   = start_q;
  assign bus.cur_master   = cur_q;
  assign bus.protocol_err = perr_q;
  assign bus.timeout_err  = terr_q;

endmodule

// File: tb/tb_ubus_arbiter.sv
// Directed self-checking bench for ubus_arbiter with two masters.
module tb_ubus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ubus_if #(.NUM_MASTERS(2)) bus ();

  ubus_arbiter #(
    .NUM_MASTERS (2),
    .WAIT_TIMEOUT(16)
  ) dut (
    .ubus_clock(clk),
    .ubus_reset(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic st, input logic [1:0] g,
                          input logic c, input logic pe, input logic te);
    chk({tag, ".start"}, 32'(bus.ubus_start), 32'(st));
    chk({tag, ".gnt"}, 32'(bus.ubus_gnt), 32'(g));
    chk({tag, ".cur"}, 32'(bus.cur_master), 32'(c));
    chk({tag, ".perr"}, 32'(bus.protocol_err), 32'(pe));
    chk({tag, ".terr"}, 32'(bus.timeout_err), 32'(te));
  endtask

  // Runs one transfer from its ARB cycle to the next ARB cycle.
  task automatic xfer(input string tag, input logic [1:0] g, input logic c,
                      input logic rd, input logic wr, input logic [1:0] sz,
                      input int wa, input int wb, input int wlen, input int badb,
                      input int exp_dc, input int exp_perr);
    int   nbeats, beat, wc, dc, pc, tc;
    logic w;
    bit   done;
    nbeats = 1 << sz;
    chk_outs({tag, ".arb"}, 1'b1, g, c, 1'b0, 1'b0);
    bus.ubus_read  = rd;
    bus.ubus_write = wr;
    bus.ubus_size  = sz;
    bus.ubus_bip   = 1'b0;
    bus.ubus_wait  = 1'b0;
    bus.ubus_error = 1'b0;
    step();
    chk_outs({tag, ".addr"}, 1'b0, g, c, 1'b0, 1'b0);
    step();
    beat = 1; wc = 0; dc = 0; pc = 0; tc = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      chk({tag, ".held"}, 32'(bus.ubus_gnt), 32'(g));
      w = ((beat == wa) || (beat == wb)) && (wc < wlen);
      bus.ubus_wait = w;
      bus.ubus_bip  = (beat < nbeats) ^ (beat == badb);
      step();
      dc++;
      pc += int'(bus.protocol_err);
      tc += int'(bus.timeout_err);
      if (w) wc++;
      else begin
        beat++;
        wc = 0;
      end
      if (bus.ubus_start) done = 1'b1;
    end
    bus.ubus_wait = 1'b0;
    bus.ubus_bip  = 1'b0;
    chk({tag, ".data_cycles"}, 32'(dc), 32'(exp_dc));
    chk({tag, ".perr_pulses"}, 32'(pc), 32'(exp_perr));
    chk({tag, ".terr_pulses"}, 32'(tc), 32'd0);
  endtask

  initial begin
    int n;
    bit done;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.ubus_req   = 2'b00;
    bus.ubus_read  = 1'b0;
    bus.ubus_write = 1'b0;
    bus.ubus_size  = 2'd0;
    bus.ubus_bip   = 1'b0;
    bus.ubus_wait  = 1'b0;
    bus.ubus_error = 1'b0;
    step(); step(); step();
    chk_outs("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Single requester, 1-beat write: ARB/ADDR/DATA with grant 01.
    bus.ubus_req = 2'b01;
    rst_n = 1'b1;
    step();
    xfer("t1", 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);

    // Both requesting: alternation.
    bus.ubus_req = 2'b11;
    xfer("t2a", 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);
    xfer("t2b", 2'b10, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);
    xfer("t2c", 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);
    xfer("t2d", 2'b10, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);

    // 8-beat read, two 2-cycle stalls: 12 data cycles.
    xfer("t3", 2'b01, 1'b0, 1'b1, 1'b0, 2'd3, 2, 5, 2, 0, 12, 0);
    // 4-beat write with bad bip on beat 1.
    xfer("t4", 2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 0, 0, 0, 1, 4, 1);

    // Wait held high until timeout.
    chk_outs("to.arb", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    bus.ubus_write = 1'b1;
    bus.ubus_read  = 1'b0;
    bus.ubus_size  = 2'd0;
    step();
    step();
    bus.ubus_wait = 1'b1;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      n++;
      if (bus.ubus_start) done = 1'b1;
    end
    chk("to.cycles", 32'(n), 32'd16);
    chk_outs("to.end", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    bus.ubus_wait  = 1'b0;
    bus.ubus_write = 1'b0;
    step();
    chk_outs("to.pulse", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    step();
    chk_outs("nop.arb", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

    // Read and write together: protocol error, treated as NOP.
    bus.ubus_read  = 1'b1;
    bus.ubus_write = 1'b1;
    step();
    chk_outs("both.addr", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("both.arb", 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    bus.ubus_read  = 1'b0;
    bus.ubus_write = 1'b0;
    step();
    chk_outs("both.pulse", 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);

    // Idle bus alternates ARB/ADDR with no grant.
    bus.ubus_req = 2'b00;
    step();
    chk_outs("idle.arb", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("idle.addr", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    chk_outs("idle.arb2", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    bus.ubus_req = 2'b11;
    step();
    step();
    chk_outs("rr.resume", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

    // Slave error on beat 2 of an 8-beat read.
    bus.ubus_read = 1'b1;
    bus.ubus_size = 2'd3;
    step();
    step();
    bus.ubus_bip = 1'b1;
    step();
    bus.ubus_error = 1'b1;
    bus.ubus_wait  = 1'b1;
    step();
    chk_outs("err.arb", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    bus.ubus_error = 1'b0;
    bus.ubus_wait  = 1'b0;
    bus.ubus_bip   = 1'b0;
    bus.ubus_read  = 1'b0;
    xfer("t6", 2'b10, 1'b1, 1'b0, 1'b1, 2'd0, 0, 0, 0, 0, 1, 0);

    // Reset mid-DATA: outputs clear, master 0 favoured again.
    chk_outs("rst.arb", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    bus.ubus_write = 1'b1;
    bus.ubus_size  = 2'd3;
    step();
    step();
    bus.ubus_bip = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    chk_outs("rst.hold", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    bus.ubus_bip   = 1'b0;
    bus.ubus_write = 1'b0;
    step();
    chk_outs("rst.arb2", 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
